// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the TX and RX paths.
//   - mux select encodings for the TX output mux
//   - FSM state encodings
//   - parity helper
package uart_pkg;

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_DATA   = 2'b01;
  localparam logic [1:0] SEL_PARITY = 2'b10;
  localparam logic [1:0] SEL_STOP   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Parity bit over a zero-extended byte; odd=1 inverts for odd parity.
  function automatic logic calc_parity(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time counter for the UART.
// Counts 0..CLKS_PER_BIT-1 and wraps; held at 0 while clear is high.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   clear         hold counter at 0 (idle)
//   bit_end       high in the last cycle of a bit time
//   bit_pre_end   high in the second-to-last cycle of a bit time
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end,
  output logic bit_pre_end
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] PRE  = W'(CLKS_PER_BIT - 2);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (clear || bit_end)  cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end

  assign bit_end     = (cnt == LAST);
  assign bit_pre_end = (cnt == PRE);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer.
// Accepts a byte over valid/ready and steers the TX output mux through
// start, LSB-first data, optional parity and stop bits, each CLKS_PER_BIT
// cycles long.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit
// (even, or odd when PARITY_ODD=1). Without it, DATA goes straight to STOP
// and mux_parity_bit is tied 0.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   tx_data          byte to send, sampled on handshake
//   tx_valid         byte available
//   tx_ready         idle, can accept a byte (registered)
//   tx_done          one-cycle pulse in the last cycle of the last stop bit
//   mux_sel          00 start, 01 data, 10 parity, 11 stop/idle
//   mux_data_bit     current data bit (1 outside DATA)
//   mux_parity_bit   parity of the captured byte
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_done,
  output logic [1:0]           mux_sel,
  output logic                 mux_data_bit,
  output logic                 mux_parity_bit
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e          state;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           bit_idx;
  logic                 stop_idx;
  logic                 bit_end;
  logic                 bit_pre_end;

  // Counter idles at 0, so the first bit after an accept starts from 0.
  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (state == ST_IDLE),
    .bit_end     (bit_end),
    .bit_pre_end (bit_pre_end)
  );

`ifndef UART_TX_PARITY_EN
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
  assign mux_parity_bit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      shift        <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      tx_ready     <= 1'b1;
      tx_done      <= 1'b0;
      mux_sel      <= SEL_STOP;
      mux_data_bit <= 1'b1;
`ifdef UART_TX_PARITY_EN
      mux_parity_bit <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_valid && tx_ready) begin
            shift    <= tx_data;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            tx_ready <= 1'b0;
            mux_sel  <= SEL_START;
            state    <= ST_START;
`ifdef UART_TX_PARITY_EN
            mux_parity_bit <= calc_parity(8'(tx_data), 1'(PARITY_ODD));
`endif
          end
        end

        ST_START: begin
          if (bit_end) begin
            state        <= ST_DATA;
            mux_sel      <= SEL_DATA;
            mux_data_bit <= shift[0];
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == LAST_BIT) begin
              mux_data_bit <= 1'b1;
              stop_idx     <= 1'b0;
`ifdef UART_TX_PARITY_EN
              state   <= ST_PARITY;
              mux_sel <= SEL_PARITY;
`else
              state   <= ST_STOP;
              mux_sel <= SEL_STOP;
`endif
            end else begin
              // Present the next bit before the shift lands.
              mux_data_bit <= shift[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            state   <= ST_STOP;
            mux_sel <= SEL_STOP;
          end
        end
`endif

        ST_STOP: begin
          // Registered pulse, so it is armed one cycle early to land in
          // the final cycle of the final stop bit.
          if (bit_pre_end && stop_idx == LAST_STOP)
            tx_done <= 1'b1;
          if (bit_end) begin
            if (stop_idx == LAST_STOP) begin
              state    <= ST_IDLE;
              tx_ready <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end

        default: begin
          state        <= ST_IDLE;
          tx_ready     <= 1'b1;
          mux_sel      <= SEL_STOP;
          mux_data_bit <= 1'b1;
        end
      endcase
    end
  end

endmodule
